// File: rtl/spi_mem_slave_pkg.sv
// Shared types and constants for the SPI memory slave and its bit engine.
package spi_mem_pkg;

    typedef enum logic [2:0] {
        ADDR,
        CMD,
        WRITE,
        READ,
        DONE
    } state_t;

    localparam logic [7:0] CMD_READ = 8'h00;
    localparam logic [7:0] IDLE_TX  = 8'h00;

endpackage

// File: rtl/spi_mem_slave_bit_engine.sv
// SPI bit engine: synchronises nCS/SCK/MOSI into the CLK domain and handles
// mode-dependent sampling, MISO presentation, byte framing and framing errors.
module spi_bit_engine #(
    parameter int unsigned CPOL      = 0,
    parameter int unsigned CPHA      = 0,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       sck,
    input  logic       mosi,
    input  logic       tx_load,
    input  logic [7:0] tx_byte,
    output logic       miso,
    output logic       active,
    output logic       byte_done,
    output logic       frame_end,
    output logic       frame_err,
    output logic [7:0] rx_byte
);

    localparam bit POL = (CPOL != 0);
    localparam bit PHA = (CPHA != 0);
    localparam bit MSB = (MSB_FIRST != 0);

    logic [1:0] cs_s, sck_s, mosi_s;
    logic       sck_d;
    logic [7:0] rx_sr, tx_reg, rx_next;
    logic [2:0] bitcnt;
    logic       sck_rise, sck_fall, lead, trail;
    logic       sample_ev, shift_ev, cs_fall, cs_rise, last_bit, tx_bit;

    always_comb begin
        sck_rise  = sck_s[1] & ~sck_d;
        sck_fall  = ~sck_s[1] & sck_d;
        lead      = POL ? sck_fall : sck_rise;
        trail     = POL ? sck_rise : sck_fall;
        // active is the synchronised nCS of the previous cycle, so an edge that
        // coincides with the nCS rise still counts and can complete the byte
        sample_ev = active & (PHA ? trail : lead);
        shift_ev  = active & (PHA ? lead : trail);
        cs_fall   = ~active & ~cs_s[1];
        cs_rise   = active & cs_s[1];
        rx_next   = MSB ? {rx_sr[6:0], mosi_s[1]} : {mosi_s[1], rx_sr[7:1]};
        last_bit  = sample_ev && (bitcnt == 3'd7);
        tx_bit    = MSB ? tx_reg[3'd7 - bitcnt] : tx_reg[bitcnt];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_s      <= '1;
            sck_s     <= {2{POL}};
            sck_d     <= POL;
            mosi_s    <= '0;
            active    <= 1'b0;
            bitcnt    <= '0;
            rx_sr     <= '0;
            rx_byte   <= '0;
            tx_reg    <= '0;
            miso      <= 1'b0;
            byte_done <= 1'b0;
            frame_end <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cs_s      <= {cs_s[0], cs_n};
            sck_s     <= {sck_s[0], sck};
            mosi_s    <= {mosi_s[0], mosi};
            sck_d     <= sck_s[1];
            active    <= ~cs_s[1];
            byte_done <= last_bit;
            frame_end <= cs_rise;
            frame_err <= cs_rise && (bitcnt != 3'd0) && !last_bit;
            if (sample_ev) begin
                rx_sr  <= rx_next;
                bitcnt <= bitcnt + 3'd1;
            end
            if (last_bit)
                rx_byte <= rx_next;
            if (cs_rise)
                bitcnt <= '0;
            if (tx_load)
                tx_reg <= tx_byte;
            // bitcnt is the index of the next bit on the wire; for CPHA=0 the
            // first bit has to be out before the first leading edge
            if (shift_ev || (cs_fall && !PHA))
                miso <= tx_bit;
        end
    end

endmodule

// File: rtl/spi_mem_slave.sv
// SPI slave with byte memory: address bytes (LSB first), command, then data.
// Define SPI_MEM_SLAVE_BURST_EN for auto-increment bursts; otherwise one data byte per frame.
module spi_mem_slave
    import spi_mem_pkg::*;
#(
    parameter int unsigned CPOL       = 0,
    parameter int unsigned CPHA       = 0,
    parameter int unsigned MSB_FIRST  = 0,
    parameter int unsigned ADDR_BYTES = 2,
    parameter int unsigned MEM_AW     = 8
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       nCS,
    input  logic       SCK,
    input  logic       MOSI,
    output logic       MISO,
    output logic       MISO_OE,
    output logic       busy,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    state_t            state;
    logic [MEM_AW-1:0] addr;
    logic [1:0]        abyte;
    logic              byte_done, frame_end, active, tx_load;
    logic [7:0]        tx_byte;
    logic [7:0]        mem [0:(1 << MEM_AW) - 1];

    spi_bit_engine #(
        .CPOL      (CPOL),
        .CPHA      (CPHA),
        .MSB_FIRST (MSB_FIRST)
    ) u_engine (
        .clk       (CLK),
        .rst_n     (nRESET),
        .cs_n      (nCS),
        .sck       (SCK),
        .mosi      (MOSI),
        .tx_load   (tx_load),
        .tx_byte   (tx_byte),
        .miso      (MISO),
        .active    (active),
        .byte_done (byte_done),
        .frame_end (frame_end),
        .frame_err (frame_err),
        .rx_byte   (rx_byte)
    );

    assign busy     = active;
    assign MISO_OE  = active;
    assign rx_valid = byte_done;

    // tx_load lags each byte/frame event by one cycle so state and addr are settled
    always_comb begin
        tx_byte = IDLE_TX;
        if (state == READ)
            tx_byte = mem[addr];
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state   <= ADDR;
            addr    <= '0;
            abyte   <= '0;
            tx_load <= 1'b0;
        end else begin
            tx_load <= byte_done | frame_end;
            if (byte_done) begin
                unique case (state)
                    ADDR: begin
                        for (int unsigned j = 0; j < MEM_AW; j++)
                            if ((j >> 3) == {30'd0, abyte})
                                addr[j] <= rx_byte[j[2:0]];
                        abyte <= abyte + 2'd1;
                        if (abyte == 2'(ADDR_BYTES - 1)) begin
                            abyte <= '0;
                            state <= CMD;
                        end
                    end
                    CMD:         state <= (rx_byte == CMD_READ) ? READ : WRITE;
`ifdef SPI_MEM_SLAVE_BURST_EN
                    WRITE, READ: addr <= addr + 1'b1;
`else
                    WRITE, READ: state <= DONE;
`endif
                    DONE:        ;
                endcase
            end
            // a byte finishing in the same cycle is handled above before the frame ends
            if (frame_end) begin
                state <= ADDR;
                addr  <= '0;
                abyte <= '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (byte_done && state == WRITE)
            mem[addr] <= rx_byte;
    end

endmodule

// File: tb/tb_spi_mem_slave.sv
// Directed bench for spi_mem_slave: instances 0..3 cover CPOL/CPHA with MSB first,
// instance 4 is mode 0 LSB first. Expectations follow SPI_MEM_SLAVE_BURST_EN.
module tb_spi_mem_slave;

    localparam int  N    = 5;
    localparam time HALF = 50;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       mosi  = 1'b0;
    logic       ncs       [N];
    logic       sck       [N];
    logic       miso      [N];
    logic       miso_oe   [N];
    logic       busy      [N];
    logic       rx_valid  [N];
    logic       frame_err [N];
    logic [7:0] rx_byte   [N];
    int unsigned rxv_cnt  [N] = '{default: 0};
    int unsigned ferr_cnt [N] = '{default: 0};
    logic [7:0] tx_buf [8];
    logic [7:0] rx_buf [8];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_dut
        spi_mem_slave #(
            .CPOL       ((k == 2 || k == 3) ? 1 : 0),
            .CPHA       ((k == 1 || k == 3) ? 1 : 0),
            .MSB_FIRST  ((k < 4) ? 1 : 0),
            .ADDR_BYTES (2),
            .MEM_AW     (8)
        ) dut (
            .CLK       (clk),
            .nRESET    (rst_n),
            .nCS       (ncs[k]),
            .SCK       (sck[k]),
            .MOSI      (mosi),
            .MISO      (miso[k]),
            .MISO_OE   (miso_oe[k]),
            .busy      (busy[k]),
            .rx_valid  (rx_valid[k]),
            .rx_byte   (rx_byte[k]),
            .frame_err (frame_err[k])
        );
    end

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rx_valid[k] === 1'b1) rxv_cnt[k] <= rxv_cnt[k] + 1;
            if (frame_err[k] === 1'b1) ferr_cnt[k] <= ferr_cnt[k] + 1;
        end
    end

    function automatic bit cpol_of(input int d); return (d == 2 || d == 3); endfunction
    function automatic bit cpha_of(input int d); return (d == 1 || d == 3); endfunction
    function automatic bit msb_of(input int d);  return (d < 4);            endfunction

    // Master side of one byte; cs_last raises nCS together with the 8th sample edge.
    task automatic send_byte(input int d, input logic [7:0] b, input int nbits,
                             input bit cs_last, output logic [7:0] r);
        int unsigned idx;
        bit pol;
        pol = cpol_of(d);
        r = '0;
        for (int i = 0; i < nbits; i++) begin
            idx = msb_of(d) ? 7 - i : i;
            if (!cpha_of(d)) begin
                mosi = b[idx];
                #HALF;
                sck[d] = ~pol;
                r[idx] = miso[d];
                if (cs_last && i == 7) ncs[d] = 1'b1;
                #HALF;
                sck[d] = pol;
            end else begin
                sck[d] = ~pol;
                mosi = b[idx];
                #HALF;
                sck[d] = pol;
                r[idx] = miso[d];
                if (cs_last && i == 7) ncs[d] = 1'b1;
                #HALF;
            end
        end
    endtask

    task automatic xfer(input int d, input int nbytes, input int last_bits, input bit cs_last);
        ncs[d] = 1'b0;
        #(2 * HALF);
        for (int n = 0; n < nbytes; n++)
            send_byte(d, tx_buf[n], (n == nbytes - 1) ? last_bits : 8,
                      cs_last && (n == nbytes - 1), rx_buf[n]);
        #HALF;
        ncs[d] = 1'b1;
        #(4 * HALF);
    endtask

    task automatic set_tx(input logic [7:0] b0, b1, b2, b3, b4, b5);
        tx_buf[0] = b0; tx_buf[1] = b1; tx_buf[2] = b2;
        tx_buf[3] = b3; tx_buf[4] = b4; tx_buf[5] = b5;
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            tests++;
            if ({miso[k], miso_oe[k], busy[k], rx_valid[k], frame_err[k]} !== 5'b0) begin
                fails++;
                $display("FAIL reset_flags[%0d]: got miso/oe/busy/rxv/ferr=%b required 00000", k,
                         {miso[k], miso_oe[k], busy[k], rx_valid[k], frame_err[k]});
            end
            tests++;
            if (rx_byte[k] !== 8'h00) begin
                fails++;
                $display("FAIL reset_rx_byte[%0d]: got %h required 00", k, rx_byte[k]);
            end
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_busy();
        int unsigned f0;
        f0 = ferr_cnt[4];
        ncs[4] = 1'b0;
        #(4 * HALF);
        tests++;
        if ({busy[4], miso_oe[4]} !== 2'b11) begin
            fails++;
            $display("FAIL busy_low_cs: got busy/oe=%b required 11", {busy[4], miso_oe[4]});
        end
        ncs[4] = 1'b1;
        #(4 * HALF);
        tests++;
        if ({busy[4], miso_oe[4]} !== 2'b00) begin
            fails++;
            $display("FAIL busy_high_cs: got busy/oe=%b required 00", {busy[4], miso_oe[4]});
        end
        tests++;
        if (ferr_cnt[4] - f0 != 0) begin
            fails++;
            $display("FAIL busy_empty_frame_err: got %0d pulses required 0", ferr_cnt[4] - f0);
        end
    endtask

    task automatic test_write_read();
        int unsigned v0, f0;
        v0 = rxv_cnt[4]; f0 = ferr_cnt[4];
        set_tx(8'h34, 8'h12, 8'h01, 8'hA5, 8'h00, 8'h00);
        xfer(4, 4, 8, 1'b0);
        tests++;
        if (rxv_cnt[4] - v0 != 4) begin
            fails++;
            $display("FAIL wr_rx_valid_count: got %0d required 4", rxv_cnt[4] - v0);
        end
        tests++;
        if (rx_byte[4] !== 8'hA5 || ferr_cnt[4] != f0) begin
            fails++;
            $display("FAIL wr_rx_byte: got %h ferr %0d required A5 ferr 0", rx_byte[4], ferr_cnt[4] - f0);
        end
        v0 = rxv_cnt[4];
        set_tx(8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00);
        xfer(4, 4, 8, 1'b0);
        tests++;
        if (rxv_cnt[4] - v0 != 4) begin
            fails++;
            $display("FAIL rd_rx_valid_count: got %0d required 4", rxv_cnt[4] - v0);
        end
        tests++;
        if ({rx_buf[0], rx_buf[1], rx_buf[2], rx_buf[3]} !== 32'h000000A5) begin
            fails++;
            $display("FAIL rd_miso_bytes: got %h %h %h %h required 00 00 00 a5",
                     rx_buf[0], rx_buf[1], rx_buf[2], rx_buf[3]);
        end
    endtask

    task automatic test_modes();
        for (int d = 0; d < 4; d++) begin
            set_tx(8'h40, 8'h00, 8'h01, 8'h81, 8'h00, 8'h00);
            xfer(d, 4, 8, 1'b0);
            set_tx(8'h41, 8'h00, 8'h01, 8'hC5, 8'h00, 8'h00);
            xfer(d, 4, 8, 1'b0);
            tests++;
            if (rx_byte[d] !== 8'hC5) begin
                fails++;
                $display("FAIL mode%0d_rx_byte: got %h required c5", d, rx_byte[d]);
            end
            set_tx(8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
            xfer(d, 4, 8, 1'b0);
            tests++;
            if (rx_buf[3] !== 8'h81 || rx_buf[1] !== 8'h00) begin
                fails++;
                $display("FAIL mode%0d_read_81: got %h (addr byte %h) required 81 (00)", d, rx_buf[3], rx_buf[1]);
            end
            set_tx(8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
            xfer(d, 4, 8, 1'b0);
            tests++;
            if (rx_buf[3] !== 8'hC5) begin
                fails++;
                $display("FAIL mode%0d_read_c5: got %h required c5", d, rx_buf[3]);
            end
        end
    endtask

    task automatic test_frame_err();
        int unsigned v0, f0;
        set_tx(8'h50, 8'h00, 8'h01, 8'h3C, 8'h00, 8'h00);
        xfer(4, 4, 8, 1'b0);
        v0 = rxv_cnt[4]; f0 = ferr_cnt[4];
        set_tx(8'h50, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h00);
        xfer(4, 4, 5, 1'b0);
        tests++;
        if (ferr_cnt[4] - f0 != 1) begin
            fails++;
            $display("FAIL ferr_pulse: got %0d pulses required 1", ferr_cnt[4] - f0);
        end
        tests++;
        if (rxv_cnt[4] - v0 != 3) begin
            fails++;
            $display("FAIL ferr_rx_valid_count: got %0d required 3", rxv_cnt[4] - v0);
        end
        f0 = ferr_cnt[4];
        set_tx(8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        xfer(4, 4, 8, 1'b0);
        tests++;
        if (rx_buf[3] !== 8'h3C || ferr_cnt[4] != f0) begin
            fails++;
            $display("FAIL ferr_mem_kept: got %h ferr %0d required 3c ferr 0", rx_buf[3], ferr_cnt[4] - f0);
        end
    endtask

    task automatic test_cs_boundary();
        int unsigned v0, f0;
        v0 = rxv_cnt[4]; f0 = ferr_cnt[4];
        set_tx(8'h60, 8'h00, 8'h01, 8'h77, 8'h00, 8'h00);
        xfer(4, 4, 8, 1'b1);
        tests++;
        if (rxv_cnt[4] - v0 != 4 || ferr_cnt[4] != f0) begin
            fails++;
            $display("FAIL cs_edge_counts: got rxv %0d ferr %0d required 4 0", rxv_cnt[4] - v0, ferr_cnt[4] - f0);
        end
        set_tx(8'h60, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        xfer(4, 4, 8, 1'b0);
        tests++;
        if (rx_buf[3] !== 8'h77) begin
            fails++;
            $display("FAIL cs_edge_write: got %h required 77", rx_buf[3]);
        end
    endtask

`ifdef SPI_MEM_SLAVE_BURST_EN
    task automatic test_burst();
        set_tx(8'hFE, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33);
        xfer(4, 6, 8, 1'b0);
        set_tx(8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        xfer(4, 6, 8, 1'b0);
        tests++;
        if ({rx_buf[3], rx_buf[4], rx_buf[5]} !== 24'h112233) begin
            fails++;
            $display("FAIL burst_read: got %h %h %h required 11 22 33", rx_buf[3], rx_buf[4], rx_buf[5]);
        end
        set_tx(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        xfer(4, 4, 8, 1'b0);
        tests++;
        if (rx_buf[3] !== 8'h33) begin
            fails++;
            $display("FAIL burst_wrap: got %h required 33", rx_buf[3]);
        end
    endtask
`else
    task automatic test_no_burst();
        int unsigned v0;
        set_tx(8'h11, 8'h00, 8'h01, 8'h5C, 8'h00, 8'h00);
        xfer(4, 4, 8, 1'b0);
        v0 = rxv_cnt[4];
        set_tx(8'h10, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'h00);
        xfer(4, 5, 8, 1'b0);
        tests++;
        if (rxv_cnt[4] - v0 != 5) begin
            fails++;
            $display("FAIL single_rx_valid_count: got %0d required 5", rxv_cnt[4] - v0);
        end
        set_tx(8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        xfer(4, 5, 8, 1'b0);
        tests++;
        if (rx_buf[3] !== 8'hAA || rx_buf[4] !== 8'h00) begin
            fails++;
            $display("FAIL single_read: got %h %h required aa 00", rx_buf[3], rx_buf[4]);
        end
        set_tx(8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        xfer(4, 4, 8, 1'b0);
        tests++;
        if (rx_buf[3] !== 8'h5C) begin
            fails++;
            $display("FAIL single_no_second_write: got %h required 5c", rx_buf[3]);
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [7:0] r;
        int unsigned v0;
        ncs[4] = 1'b0;
        #(2 * HALF);
        send_byte(4, 8'h34, 8, 1'b0, r);
        send_byte(4, 8'h12, 8, 1'b0, r);
        send_byte(4, 8'h00, 8, 1'b0, r);
        send_byte(4, 8'h00, 3, 1'b0, r);
        tests++;
        if (r !== 8'h05) begin
            fails++;
            $display("FAIL rstmid_partial_read: got %h required 05", r);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({miso_oe[4], busy[4], miso[4], rx_valid[4]} !== 4'b0000) begin
            fails++;
            $display("FAIL rstmid_outputs: got oe/busy/miso/rxv=%b required 0000",
                     {miso_oe[4], busy[4], miso[4], rx_valid[4]});
        end
        ncs[4] = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        v0 = rxv_cnt[4];
        set_tx(8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00);
        xfer(4, 4, 8, 1'b0);
        tests++;
        if (rx_buf[3] !== 8'hA5 || rxv_cnt[4] - v0 != 4) begin
            fails++;
            $display("FAIL rstmid_retained: got %h rxv %0d required a5 rxv 4", rx_buf[3], rxv_cnt[4] - v0);
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            ncs[k] = 1'b1;
            sck[k] = cpol_of(k);
        end
        test_reset();
        test_busy();
        test_write_read();
        test_modes();
        test_frame_err();
        test_cs_boundary();
`ifdef SPI_MEM_SLAVE_BURST_EN
        test_burst();
`else
        test_no_burst();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached with %0d of %0d failed", fails, tests);
        $fatal(1);
    end

endmodule
